alu_flags_sink: RTL and testbench
=================================

// Module: alu_flags_sink
// PURPOSE
//  Execute-stage consumer of the 64-bit ALU outputs (ans, overflow) in the Y86-64 datapath.
//  Registers valE and maintains the condition-code register (ZF/SF/OF).
//  Evaluates the Y86 branch/cmov condition and counts overflow events.
//  Sits between the ALU and the E/M pipeline register; honours pipeline stall/bubble control.
// PARAMETERS
//  WIDTH      64   datapath width of ans/valE (two's complement)
//  CNT_WIDTH  16   width of the saturating overflow-event counter
// PORTS
//  clk          in   1          rising-edge clock
//  rst          in   1          synchronous reset, active-high
//  in_valid     in   1          alu_ans/alu_overflow carry a real instruction this cycle
//  alu_control  in   2          op that produced ans: 00 add, 01 sub, 10 and, 11 xor
//  alu_ans      in   WIDTH      signed ALU result
//  alu_overflow in   1          ALU signed-overflow flag
//  set_cc       in   1          update ZF/SF/OF from this result (OPq only)
//  cond_fn      in   3          0 always,1 le,2 l,3 e,4 ne,5 ge,6 g,7 illegal
//  stall        in   1          hold every register this cycle
//  bubble       in   1          inject a NOP into the output stage
//  out_valid    out  1          valE/cnd hold a real instruction
//  valE         out  WIDTH      registered alu_ans
//  zf, sf, of   out  1 each     condition-code register
//  cnd          out  1          registered condition result
//  cond_err     out  1          sticky: cond_fn==7 seen on a valid cycle
//  ovf_count    out  CNT_WIDTH  saturating count of flag updates with OF=1
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): out_valid=0, valE=0, zf=1, sf=0, of=0, cnd=0,
//   cond_err=0, ovf_count=0. rst wins over every other input.
//  Priority per edge: rst > stall > bubble > in_valid.
//  stall=1: all registers hold, including flags/counter, regardless of bubble/in_valid/set_cc.
//  bubble=1 (no stall): out_valid<=0, valE<=0, cnd<=0; flags, cond_err, ovf_count unchanged;
//   set_cc ignored.
//  in_valid=1 (no stall/bubble), 1-cycle latency:
//   out_valid<=1; valE<=alu_ans;
//   cnd<=f(cond_fn, zf,sf,of CURRENT register values, i.e. before this edge's update):
//    always=1; le=(sf^of)|zf; l=sf^of; e=zf; ne=~zf; ge=~(sf^of); g=~(sf^of)&~zf; 7 -> 0.
//   cond_fn==7 -> cond_err<=1 (sticky until rst).
//   if set_cc: zf<=(alu_ans==0); sf<=alu_ans[WIDTH-1];
//    of<=alu_overflow for control 00/01; of<=0 for 10/11 (alu_overflow ignored).
//    if new of==1 and ovf_count!=all-ones: ovf_count<=ovf_count+1; at all-ones holds.
//  in_valid=0 (no stall/bubble/rst): out_valid<=0; valE, cnd, flags, counters hold;
//   set_cc ignored.
//  Flag write and cnd read in the same cycle: cnd uses old flags (no bypass);
//   a cnd seeing the new flags is evaluated one valid cycle later.
//  No combinational path from inputs to outputs; all outputs registered.
// TESTING
//  1 rst=1 one cycle -> out_valid=0, valE=0, zf=1, sf=0, of=0, ovf_count=0, cond_err=0.
//  2 add, ans=15 (0xB+0x4), set_cc=1 -> next cycle valE=15, zf=0, sf=0, of=0, out_valid=1.
//  3 sub, ans=-15, set_cc=1, cond_fn=2 (l) -> sf=1, zf=0; cnd=0 (old flags).
//    Next valid cycle, cond_fn=2 -> cnd=1.
//  4 add, ans=0x8000_0000_0000_0000, alu_overflow=1, set_cc=1 -> of=1, sf=1, ovf_count=1;
//    same inputs with xor (11) -> of=0, ovf_count unchanged.
//  5 stall=1 with in_valid=1, set_cc=1, bubble=1 -> every output unchanged.
//    bubble alone -> out_valid=0, valE=0, flags kept.
//  6 cond_fn=7 on a valid cycle -> cnd=0, cond_err=1, stays 1 until rst.
//    Force ovf_count=0xFFFF via 65535 OF updates -> 0xFFFF holds on the next OF update.

Source files
------------

// File: rtl/alu_flags_sink.sv
// Execute-stage consumer of the Y86-64 ALU result.
// Registers valE, keeps the ZF/SF/OF condition-code register, evaluates the
// branch/cmov condition against the flags as they stand before this edge,
// and keeps a saturating count of flag updates that set OF.
//
// Handshake: there is no back-pressure. in_valid qualifies the ALU inputs for
// one cycle; out_valid qualifies valE/cnd one cycle later. stall freezes every
// register (the upstream must hold its inputs); bubble replaces the slot with
// a NOP. Per-edge priority is rst > stall > bubble > in_valid.
module alu_flags_sink #(
    parameter int WIDTH     = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [1:0]           alu_control,
    input  logic [WIDTH-1:0]     alu_ans,
    input  logic                 alu_overflow,
    input  logic                 set_cc,
    input  logic [2:0]           cond_fn,
    input  logic                 stall,
    input  logic                 bubble,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     valE,
    output logic                 zf,
    output logic                 sf,
    output logic                 of,
    output logic                 cnd,
    output logic                 cond_err,
    output logic [CNT_WIDTH-1:0] ovf_count
);

    // ALU operation codes
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    // Y86 condition function codes
    localparam logic [2:0] C_ALWAYS  = 3'd0;
    localparam logic [2:0] C_LE      = 3'd1;
    localparam logic [2:0] C_L       = 3'd2;
    localparam logic [2:0] C_E       = 3'd3;
    localparam logic [2:0] C_NE      = 3'd4;
    localparam logic [2:0] C_GE      = 3'd5;
    localparam logic [2:0] C_G       = 3'd6;
    localparam logic [2:0] C_ILLEGAL = 3'd7;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     vale_q,      vale_d;
    logic                 zf_q,        zf_d;
    logic                 sf_q,        sf_d;
    logic                 of_q,        of_d;
    logic                 cnd_q,       cnd_d;
    logic                 cond_err_q,  cond_err_d;
    logic [CNT_WIDTH-1:0] ovf_count_q, ovf_count_d;

    logic                 cond_now;
    logic                 lt_now;
    logic                 new_of;

    // Condition evaluated on the registered (pre-update) flags: no bypass
    always_comb begin
        cond_now = 1'b0;
        lt_now   = sf_q ^ of_q;
        case (cond_fn)
            C_ALWAYS:  cond_now = 1'b1;
            C_LE:      cond_now = lt_now | zf_q;
            C_L:       cond_now = lt_now;
            C_E:       cond_now = zf_q;
            C_NE:      cond_now = ~zf_q;
            C_GE:      cond_now = ~lt_now;
            C_G:       cond_now = ~lt_now & ~zf_q;
            C_ILLEGAL: cond_now = 1'b0;
            default:   cond_now = 1'b0;
        endcase
    end

    // Next-state selection following stall > bubble > in_valid priority
    always_comb begin
        out_valid_d = out_valid_q;
        vale_d      = vale_q;
        zf_d        = zf_q;
        sf_d        = sf_q;
        of_d        = of_q;
        cnd_d       = cnd_q;
        cond_err_d  = cond_err_q;
        ovf_count_d = ovf_count_q;
        // Logical ops never overflow, so the ALU flag is ignored for them
        new_of      = ((alu_control == OP_ADD) || (alu_control == OP_SUB)) ? alu_overflow : 1'b0;

        if (stall) begin
            // everything holds
        end else if (bubble) begin
            out_valid_d = 1'b0;
            vale_d      = '0;
            cnd_d       = 1'b0;
        end else if (in_valid) begin
            out_valid_d = 1'b1;
            vale_d      = alu_ans;
            cnd_d       = cond_now;
            if (cond_fn == C_ILLEGAL) begin
                cond_err_d = 1'b1;
            end
            if (set_cc) begin
                zf_d = (alu_ans == '0);
                sf_d = alu_ans[WIDTH-1];
                of_d = new_of;
                if (new_of && (ovf_count_q != '1)) begin
                    ovf_count_d = ovf_count_q + CNT_ONE;
                end
            end
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            vale_q      <= '0;
            zf_q        <= 1'b1;
            sf_q        <= 1'b0;
            of_q        <= 1'b0;
            cnd_q       <= 1'b0;
            cond_err_q  <= 1'b0;
            ovf_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            vale_q      <= vale_d;
            zf_q        <= zf_d;
            sf_q        <= sf_d;
            of_q        <= of_d;
            cnd_q       <= cnd_d;
            cond_err_q  <= cond_err_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign valE      = vale_q;
    assign zf        = zf_q;
    assign sf        = sf_q;
    assign of        = of_q;
    assign cnd       = cnd_q;
    assign cond_err  = cond_err_q;
    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_alu_flags_sink.sv
// Bench for alu_flags_sink: directed scenarios, overflow-counter saturation
// and a randomized run, all compared against a behavioural model of the
// execute-stage flag/condition rules.
module tb_alu_flags_sink;

    localparam int W  = 64;
    localparam int CW = 16;
    localparam int CNT_MAX = 65535;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid;
    logic [1:0]    alu_control;
    logic [W-1:0]  alu_ans;
    logic          alu_overflow;
    logic          set_cc;
    logic [2:0]    cond_fn;
    logic          stall;
    logic          bubble;
    logic          out_valid;
    logic [W-1:0]  valE;
    logic          zf, sf, of, cnd, cond_err;
    logic [CW-1:0] ovf_count;

    alu_flags_sink #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .alu_control  (alu_control),
        .alu_ans      (alu_ans),
        .alu_overflow (alu_overflow),
        .set_cc       (set_cc),
        .cond_fn      (cond_fn),
        .stall        (stall),
        .bubble       (bubble),
        .out_valid    (out_valid),
        .valE         (valE),
        .zf           (zf),
        .sf           (sf),
        .of           (of),
        .cnd          (cnd),
        .cond_err     (cond_err),
        .ovf_count    (ovf_count)
    );

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_fail   = 0;

    // Expected values for the next sample point, queued in output order
    logic [W-1:0] exp_q[$];

    bit           m_valid;
    logic [W-1:0] m_vale;
    bit           m_zf, m_sf, m_of, m_cnd, m_err;
    int           m_cnt;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Y86 condition rules written as signed comparisons of the flags
    function automatic bit cond_eval(input int fn, input bit z, input bit s, input bit o);
        bit less;
        less = (s != o);
        case (fn)
            0: return 1'b1;
            1: return less || z;
            2: return less;
            3: return z;
            4: return !z;
            5: return !less;
            6: return !less && !z;
            default: return 1'b0;
        endcase
    endfunction

    // Advance the model by one edge using the currently driven inputs
    task automatic model_edge();
        bit new_of;
        if (rst) begin
            m_valid = 0; m_vale = '0; m_zf = 1; m_sf = 0; m_of = 0;
            m_cnd = 0; m_err = 0; m_cnt = 0;
        end else if (stall) begin
        end else if (bubble) begin
            m_valid = 0; m_vale = '0; m_cnd = 0;
        end else if (in_valid) begin
            m_valid = 1;
            m_vale  = alu_ans;
            m_cnd   = cond_eval(int'(cond_fn), m_zf, m_sf, m_of);
            if (cond_fn == 3'd7) m_err = 1;
            if (set_cc) begin
                new_of = (alu_control <= 2'd1) ? alu_overflow : 1'b0;
                m_zf = (alu_ans == 0);
                m_sf = $signed(alu_ans) < 0;
                m_of = new_of;
                if (new_of && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            end
        end else begin
            m_valid = 0;
        end
    endtask

    task automatic check_all(input string t);
        exp_q.push_back(W'(m_valid));
        exp_q.push_back(m_vale);
        exp_q.push_back(W'(m_zf));
        exp_q.push_back(W'(m_sf));
        exp_q.push_back(W'(m_of));
        exp_q.push_back(W'(m_cnd));
        exp_q.push_back(W'(m_err));
        exp_q.push_back(W'(m_cnt));
        check({t, "_out_valid"}, W'(out_valid), exp_q.pop_front());
        check({t, "_valE"},      valE,          exp_q.pop_front());
        check({t, "_zf"},        W'(zf),        exp_q.pop_front());
        check({t, "_sf"},        W'(sf),        exp_q.pop_front());
        check({t, "_of"},        W'(of),        exp_q.pop_front());
        check({t, "_cnd"},       W'(cnd),       exp_q.pop_front());
        check({t, "_cond_err"},  W'(cond_err),  exp_q.pop_front());
        check({t, "_ovf_count"}, W'(ovf_count), exp_q.pop_front());
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        rst = 0; in_valid = 0; alu_control = 2'd0; alu_ans = '0;
        alu_overflow = 0; set_cc = 0; cond_fn = 3'd0; stall = 0; bubble = 0;
    endtask

    task automatic step(input string t, input bit chk);
        model_edge();
        @(posedge clk);
        #1;
        if (chk) check_all(t);
        idle_inputs();
    endtask

    task automatic drive_op(input logic [1:0] ctl, input logic [W-1:0] ans, input bit ovf,
                            input bit scc, input logic [2:0] fn);
        in_valid = 1; alu_control = ctl; alu_ans = ans; alu_overflow = ovf;
        set_cc = scc; cond_fn = fn;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] saved_vale;
        idle_inputs();
        m_valid = 0; m_vale = '0; m_zf = 1; m_sf = 0; m_of = 0; m_cnd = 0; m_err = 0; m_cnt = 0;

        // 1: reset
        @(negedge clk);
        rst = 1;
        step("reset", 1);
        check("reset_zf_const", W'(zf), 64'd1);

        // 2: add 0xB+0x4
        drive_op(2'b00, 64'd15, 0, 1, 3'd0);
        step("add15", 1);
        check("add15_vale_const", valE, 64'd15);

        // 3: sub giving -15, cond l evaluated on old flags, then on new ones
        drive_op(2'b01, -64'sd15, 0, 1, 3'd2);
        step("sub_neg", 1);
        check("sub_neg_cnd_old", W'(cnd), 64'd0);
        drive_op(2'b10, 64'd3, 0, 0, 3'd2);
        step("l_after", 1);
        check("l_after_cnd_new", W'(cnd), 64'd1);

        // 4: signed overflow on add, then same with xor
        drive_op(2'b00, 64'h8000_0000_0000_0000, 1, 1, 3'd0);
        step("ovf_add", 1);
        check("ovf_add_cnt_const", W'(ovf_count), 64'd1);
        drive_op(2'b11, 64'h8000_0000_0000_0000, 1, 1, 3'd0);
        step("ovf_xor", 1);
        check("ovf_xor_of_const", W'(of), 64'd0);

        // 5: stall dominates everything, then bubble alone
        saved_vale = valE;
        drive_op(2'b00, 64'd0, 1, 1, 3'd7);
        stall = 1; bubble = 1;
        step("stall", 1);
        check("stall_vale_hold", valE, saved_vale);
        bubble = 1; in_valid = 1; set_cc = 1; alu_ans = 64'd0;
        step("bubble", 1);

        // idle cycle: out_valid drops, rest holds
        step("idle", 1);

        // 6: illegal condition is sticky
        drive_op(2'b10, 64'd1, 0, 0, 3'd7);
        step("illegal", 1);
        check("illegal_err_const", W'(cond_err), 64'd1);
        for (int i = 0; i < 3; i++) begin
            drive_op(2'($urandom_range(0, 3)), {$urandom, $urandom}, 1'($urandom), 1'($urandom), 3'($urandom_range(0, 6)));
            step("err_sticky", 1);
        end

        // Saturate the overflow counter
        rst = 1;
        step("rst2", 1);
        for (int i = 0; i < CNT_MAX; i++) begin
            drive_op(2'b01, 64'h7FFF_0000_0000_0001, 1, 1, 3'd0);
            step("sat_fill", 0);
        end
        check_all("sat_full");
        check("sat_full_const", W'(ovf_count), 64'hFFFF);
        drive_op(2'b00, 64'h8000_0000_0000_0000, 1, 1, 3'd0);
        step("sat_hold", 1);
        check("sat_hold_const", W'(ovf_count), 64'hFFFF);

        // Randomized run
        for (int i = 0; i < 2000; i++) begin
            int kind;
            in_valid     = ($urandom_range(0, 3) != 0);
            alu_control  = 2'($urandom_range(0, 3));
            kind         = $urandom_range(0, 3);
            case (kind)
                0:       alu_ans = '0;
                1:       alu_ans = W'($urandom_range(0, 20)) - 64'd10;
                default: alu_ans = {$urandom, $urandom};
            endcase
            alu_overflow = ($urandom_range(0, 2) == 0);
            set_cc       = 1'($urandom);
            cond_fn      = 3'($urandom_range(0, 7));
            stall        = ($urandom_range(0, 9) == 0);
            bubble       = ($urandom_range(0, 9) == 0);
            rst          = ($urandom_range(0, 199) == 0);
            step("rand", 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
